// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue stage: unit-select codes,
// FSM state codes and default widths.
package alu_pkg;

  // Default widths used by the interface and the issue controller
  localparam int A_WIDTH_DEF    = 16;
  localparam int B_WIDTH_DEF    = 16;
  localparam int FUN_WIDTH_DEF  = 4;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_WIDTH_DEF  = 16;

  // Unit-select codes carried in alu_fun[3:2]; each code is also the bit
  // index of that unit's enable inside the one-hot enable vector.
  localparam logic [1:0] SEL_ARITH = 2'b00;
  localparam logic [1:0] SEL_LOGIC = 2'b01;
  localparam logic [1:0] SEL_CMP   = 2'b10;
  localparam logic [1:0] SEL_SHIFT = 2'b11;

  // Issue FSM state codes (2-bit encoding)
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ISSUE = 2'b01;
  localparam logic [1:0] HOLD  = 2'b10;

  // Unit select field of a function code
  function automatic logic [1:0] unit_sel(input logic [3:0] fun);
    return fun[3:2];
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command bus into the issue stage: valid/ready handshake plus operands
// and function code. The producer uses the master modport, the issue
// controller the slave modport.
interface alu_issue_ctrl_if
  import alu_pkg::*;
#(
  parameter int A_WIDTH   = A_WIDTH_DEF,
  parameter int B_WIDTH   = B_WIDTH_DEF,
  parameter int FUN_WIDTH = FUN_WIDTH_DEF
) ();

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [A_WIDTH-1:0]   cmd_a;
  logic [B_WIDTH-1:0]   cmd_b;
  logic [FUN_WIDTH-1:0] cmd_fun;

  modport master (
    output cmd_valid,
    output cmd_a,
    output cmd_b,
    output cmd_fun,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_a,
    input  cmd_b,
    input  cmd_fun,
    output cmd_ready
  );

endinterface

// File: rtl/alu_issue_ctrl_cmd_fifo.sv
// Small synchronous command FIFO. Head entry is visible combinationally
// so the issue register can load it on the same edge as the pop.
// Pointers wrap naturally because DEPTH is a power of two.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DATA_W = A_WIDTH_DEF + B_WIDTH_DEF + FUN_WIDTH_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses pushes even if it pops on the same edge
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the ARITH/LOGIC/CMP/SHIFT units. Buffers
// commands, pops at most one per cycle when not held, drives registered
// operands with a one-hot unit enable, and flags the cycle in which the
// selected unit's registered result is valid.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int a_WIDTH       = A_WIDTH_DEF,
  parameter int b_WIDTH       = B_WIDTH_DEF,
  parameter int alu_fun_WIDTH = FUN_WIDTH_DEF,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF,
  localparam int FCNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_issue,
  alu_issue_ctrl_if.slave        cmd,
  input  logic                   hold,
  output logic [a_WIDTH-1:0]     a_out,
  output logic [b_WIDTH-1:0]     b_out,
  output logic [1:0]             fun_out,
  output logic                   arith_enable,
  output logic                   logic_enable,
  output logic                   cmp_enable,
  output logic                   shift_enable,
  output logic                   result_valid,
  output logic [1:0]             result_sel,
  output logic [FCNT_W-1:0]      fifo_count,
  output logic [CNT_WIDTH-1:0]   issued_cnt,
  output logic                   busy
);

  localparam int DATA_W = a_WIDTH + b_WIDTH + alu_fun_WIDTH;

  // FIFO side
  logic [DATA_W-1:0]        wdata;
  logic [DATA_W-1:0]        rdata;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push_ok;
  logic                     pop;
  logic [FCNT_W-1:0]        count_after;

  // Head entry fields
  logic [a_WIDTH-1:0]       head_a;
  logic [b_WIDTH-1:0]       head_b;
  logic [alu_fun_WIDTH-1:0] head_fun;
  logic [1:0]               head_sel;

  // Issue, tracking and FSM registers
  logic [a_WIDTH-1:0]       a_q, a_d;
  logic [b_WIDTH-1:0]       b_q, b_d;
  logic [1:0]               fun_q, fun_d;
  logic [3:0]               en_q, en_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     pending_q, pending_d;
  logic [1:0]               sel_q, sel_d;
  logic                     rv_q, rv_d;
  logic [1:0]               rsel_q, rsel_d;
  logic [1:0]               state_q, state_d;

  assign wdata    = {cmd.cmd_a, cmd.cmd_b, cmd.cmd_fun};
  assign head_a   = rdata[DATA_W-1 -: a_WIDTH];
  assign head_b   = rdata[alu_fun_WIDTH +: b_WIDTH];
  assign head_fun = rdata[alu_fun_WIDTH-1:0];
  assign head_sel = unit_sel(head_fun[3:0]);

  // Ready is purely !full, so it is high throughout reset
  assign cmd.cmd_ready = ~fifo_full;
  assign push_ok       = cmd.cmd_valid & ~fifo_full;

  // Pop whenever something is queued and the units are not stalled;
  // the popped entry appears on the unit bus after this edge.
  assign pop = ~fifo_empty & ~hold;

  // Occupancy the FIFO will hold after this edge, for the FSM
  assign count_after = fifo_count + FCNT_W'(push_ok) - FCNT_W'(pop);

  alu_cmd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_issue),
    .push_i  (cmd.cmd_valid),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // One-hot unit decode: enable bit gi fires for unit-select code gi
  for (genvar gi = 0; gi < 4; gi++) begin : g_en
    assign en_d[gi] = pop & (head_sel == 2'(gi));
  end

  // Issue register and result-tracking next-state
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    fun_d     = fun_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    pending_d = pop;
    rv_d      = pending_q;
    rsel_d    = pending_q ? sel_q : rsel_q;
    if (pop) begin
      a_d   = head_a;
      b_d   = head_b;
      fun_d = head_fun[1:0];
      sel_d = head_sel;
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // FSM next-state; state mainly qualifies busy
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = hold ? HOLD : ISSUE;
      end
      ISSUE: begin
        if (hold)                   state_d = HOLD;
        else if (count_after == '0) state_d = IDLE;
      end
      HOLD: begin
        if (fifo_empty)  state_d = IDLE;
        else if (!hold)  state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All issue-stage registers; reset clears enables and result flags at once
  always_ff @(posedge clk or negedge rst_issue) begin
    if (!rst_issue) begin
      a_q       <= '0;
      b_q       <= '0;
      fun_q     <= '0;
      en_q      <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      sel_q     <= '0;
      rv_q      <= 1'b0;
      rsel_q    <= '0;
      state_q   <= IDLE;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      fun_q     <= fun_d;
      en_q      <= en_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      rv_q      <= rv_d;
      rsel_q    <= rsel_d;
      state_q   <= state_d;
    end
  end

  assign a_out        = a_q;
  assign b_out        = b_q;
  assign fun_out      = fun_q;
  assign arith_enable = en_q[SEL_ARITH];
  assign logic_enable = en_q[SEL_LOGIC];
  assign cmp_enable   = en_q[SEL_CMP];
  assign shift_enable = en_q[SEL_SHIFT];
  assign result_valid = rv_q;
  assign result_sel   = rsel_q;
  assign issued_cnt   = cnt_q;
  assign busy         = (state_q != IDLE) | pending_q | rv_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a table of single-command vectors
// followed by hand-written multi-cycle sequences.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_issue = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] a_out, b_out;
  logic [1:0]  fun_out;
  logic        arith_enable, logic_enable, cmp_enable, shift_enable;
  logic        result_valid;
  logic [1:0]  result_sel;
  logic [2:0]  fifo_count;
  logic [15:0] issued_cnt;
  logic        busy;
  logic [3:0]  en;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [15:0] exp_cnt = 16'h0000;

  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.A_WIDTH(16), .B_WIDTH(16), .FUN_WIDTH(4)) cmd_bus ();

  alu_issue_ctrl dut (
    .clk          (clk),
    .rst_issue    (rst_issue),
    .cmd          (cmd_bus),
    .hold         (hold),
    .a_out        (a_out),
    .b_out        (b_out),
    .fun_out      (fun_out),
    .arith_enable (arith_enable),
    .logic_enable (logic_enable),
    .cmp_enable   (cmp_enable),
    .shift_enable (shift_enable),
    .result_valid (result_valid),
    .result_sel   (result_sel),
    .fifo_count   (fifo_count),
    .issued_cnt   (issued_cnt),
    .busy         (busy)
  );

  assign en = {shift_enable, cmp_enable, logic_enable, arith_enable};

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fun;
    logic [3:0]  exp_en;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    cmd_bus.cmd_valid = v;
    cmd_bus.cmd_a     = a;
    cmd_bus.cmd_b     = b;
    cmd_bus.cmd_fun   = f;
  endtask

  // Sequence tables for the hand-written corner cases
  logic [15:0] a2   [5];
  logic [3:0]  f2   [5];
  logic [3:0]  e2   [5];
  logic [1:0]  s2   [5];
  logic [2:0]  c2   [5];
  logic [19:0] model_q [$];
  logic [19:0] head;
  int          rv_pulses;
  int          remaining;

  initial begin
    vt[0] = '{16'h0005, 16'h0003, 4'b1010, 4'b0100, 2'b10};
    vt[1] = '{16'h1234, 16'h00FF, 4'b0000, 4'b0001, 2'b00};
    vt[2] = '{16'hFFFF, 16'h0001, 4'b0001, 4'b0001, 2'b00};
    vt[3] = '{16'hA5A5, 16'h5A5A, 4'b0110, 4'b0010, 2'b01};
    vt[4] = '{16'h0000, 16'hFFFF, 4'b0111, 4'b0010, 2'b01};
    vt[5] = '{16'h8000, 16'h7FFF, 4'b1001, 4'b0100, 2'b10};
    vt[6] = '{16'h00F0, 16'h0004, 4'b1100, 4'b1000, 2'b11};
    vt[7] = '{16'hDEAD, 16'hBEEF, 4'b1111, 4'b1000, 2'b11};

    drive(1'b0, 16'h0, 16'h0, 4'h0);

    // Reset state while rst_issue is low
    #1;
    chk("rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_issued", 32'(issued_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_issue = 1'b1;
    tick();

    // Table: one command at a time through an empty FIFO
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vt[i].a, vt[i].b, vt[i].fun);
      chk("tbl_ready", 32'(cmd_bus.cmd_ready), 32'd1);
      tick();                                         // accept edge
      cmd_bus.cmd_valid = 1'b0;
      chk("tbl_en_e0", 32'(en), 32'd0);
      chk("tbl_cnt_e0", 32'(fifo_count), 32'd1);
      tick();                                         // issue edge
      exp_cnt = exp_cnt + 16'd1;
      chk("tbl_en", 32'(en), 32'(vt[i].exp_en));
      chk("tbl_a", 32'(a_out), 32'(vt[i].a));
      chk("tbl_b", 32'(b_out), 32'(vt[i].b));
      chk("tbl_fun", 32'(fun_out), 32'(vt[i].fun[1:0]));
      chk("tbl_rv_e1", 32'(result_valid), 32'd0);
      chk("tbl_issued", 32'(issued_cnt), 32'(exp_cnt));
      chk("tbl_cnt_e1", 32'(fifo_count), 32'd0);
      tick();                                         // units capture
      chk("tbl_en_e2", 32'(en), 32'd0);
      chk("tbl_rv", 32'(result_valid), 32'd1);
      chk("tbl_rsel", 32'(result_sel), 32'(vt[i].exp_sel));
      chk("tbl_a_hold", 32'(a_out), 32'(vt[i].a));
      tick();
      chk("tbl_rv_off", 32'(result_valid), 32'd0);
      chk("tbl_busy_off", 32'(busy), 32'd0);
      $display("vector %0d: a=%h b=%h fun=%b applied", i, vt[i].a, vt[i].b, vt[i].fun);
    end

    // Fill under hold, fifth push refused, then drain in order
    a2 = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004};
    f2 = '{4'b0001, 4'b0110, 4'b1011, 4'b1100, 4'b0010};
    e2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    s2 = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    c2 = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, a2[i], 16'h2000 + 16'(i), f2[i]);
      chk("full_ready", 32'(cmd_bus.cmd_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready5", 32'(cmd_bus.cmd_ready), 32'd0);
    chk("full_en", 32'(en), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    hold = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 1) cmd_bus.cmd_valid = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      chk("drain_en", 32'(en), 32'(e2[k]));
      chk("drain_a", 32'(a_out), 32'(a2[k]));
      chk("drain_count", 32'(fifo_count), 32'(c2[k]));
      if (k > 0) begin
        chk("drain_rv", 32'(result_valid), 32'd1);
        chk("drain_rsel", 32'(result_sel), 32'(s2[k-1]));
      end
      $display("drain %0d: en=%b a_out=%h", k, en, a_out);
    end
    tick();
    chk("drain_tail_en", 32'(en), 32'd0);
    chk("drain_tail_rsel", 32'(result_sel), 32'(s2[4]));
    chk("drain_issued", 32'(issued_cnt), 32'(exp_cnt));
    tick();
    chk("drain_tail_rv", 32'(result_valid), 32'd0);

    // Hold pulsed for two cycles while issuing
    hold = 1'b1;
    drive(1'b1, 16'h3000, 16'h3100, 4'b0100); tick();
    drive(1'b1, 16'h3001, 16'h3101, 4'b1000); tick();
    drive(1'b1, 16'h3002, 16'h3102, 4'b1100); tick();
    cmd_bus.cmd_valid = 1'b0;
    hold = 1'b0;
    tick();
    chk("hp_en0", 32'(en), 32'b0010);
    chk("hp_a0", 32'(a_out), 32'h3000);
    hold = 1'b1;
    tick();
    chk("hp_en_h1", 32'(en), 32'd0);
    chk("hp_rv_h1", 32'(result_valid), 32'd1);
    chk("hp_rsel_h1", 32'(result_sel), 32'b01);
    chk("hp_a_h1", 32'(a_out), 32'h3000);
    chk("hp_b_h1", 32'(b_out), 32'h3100);
    tick();
    chk("hp_en_h2", 32'(en), 32'd0);
    chk("hp_rv_h2", 32'(result_valid), 32'd0);
    chk("hp_a_h2", 32'(a_out), 32'h3000);
    chk("hp_b_h2", 32'(b_out), 32'h3100);
    chk("hp_count_h2", 32'(fifo_count), 32'd2);
    hold = 1'b0;
    tick();
    chk("hp_en1", 32'(en), 32'b0100);
    chk("hp_a1", 32'(a_out), 32'h3001);
    tick();
    chk("hp_en2", 32'(en), 32'b1000);
    chk("hp_a2", 32'(a_out), 32'h3002);
    chk("hp_rsel2", 32'(result_sel), 32'b10);
    tick();
    chk("hp_rsel3", 32'(result_sel), 32'b11);
    chk("hp_rv3", 32'(result_valid), 32'd1);
    tick();
    exp_cnt = exp_cnt + 16'd3;
    $display("hold pulse sequence done");

    // Steady push+pop with two entries queued for 20 cycles
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'h4000 + 16'(i), 16'h5000 + 16'(i), 4'(i));
      model_q.push_back({4'(i), 16'h4000 + 16'(i)});
      tick();
    end
    hold = 1'b0;
    rv_pulses = 0;
    for (int i = 2; i < 22; i++) begin
      drive(1'b1, 16'h4000 + 16'(i), 16'h5000 + 16'(i), 4'(i));
      model_q.push_back({4'(i), 16'h4000 + 16'(i)});
      tick();
      head = model_q.pop_front();
      exp_cnt = exp_cnt + 16'd1;
      chk("st_en", 32'(en), 32'(4'b0001 << head[19:18]));
      chk("st_a", 32'(a_out), 32'(head[15:0]));
      chk("st_count", 32'(fifo_count), 32'd2);
      if (result_valid) rv_pulses++;
    end
    cmd_bus.cmd_valid = 1'b0;
    tick();
    if (result_valid) rv_pulses++;
    chk("st_rv_pulses", 32'(rv_pulses), 32'd20);
    head = model_q.pop_front();
    exp_cnt = exp_cnt + 16'd1;
    chk("st_tail_a1", 32'(a_out), 32'(head[15:0]));
    tick();
    head = model_q.pop_front();
    exp_cnt = exp_cnt + 16'd1;
    chk("st_tail_a2", 32'(a_out), 32'(head[15:0]));
    tick();
    chk("st_empty", 32'(fifo_count), 32'd0);
    chk("st_issued", 32'(issued_cnt), 32'(exp_cnt));
    $display("streaming sequence done, %0d result pulses", rv_pulses);

    // Stream enough ops to wrap issued_cnt through all-ones to zero
    remaining = 65536 - int'(exp_cnt);
    for (int i = 0; i < remaining; i++) begin
      drive(1'b1, 16'(i), 16'(i), 4'(i));
      tick();
    end
    cmd_bus.cmd_valid = 1'b0;
    chk("wrap_ffff", 32'(issued_cnt), 32'h0000FFFF);
    tick();
    tick();
    chk("wrap_zero", 32'(issued_cnt), 32'h00000000);
    chk("wrap_empty", 32'(fifo_count), 32'd0);
    exp_cnt = 16'h0000;
    $display("counter wrap sequence done after %0d ops", remaining);

    // Asynchronous reset in the middle of a burst
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h6000 + 16'(i), 16'h6100, 4'b0101);
      tick();
    end
    hold = 1'b0;
    drive(1'b1, 16'h6004, 16'h6100, 4'b0101);
    tick();
    tick();
    cmd_bus.cmd_valid = 1'b0;
    chk("mr_count_pre", 32'(fifo_count), 32'd3);
    chk("mr_rv_pre", 32'(result_valid), 32'd1);
    chk("mr_en_pre", 32'(en), 32'b0010);
    #2;
    rst_issue = 1'b0;
    #1;
    chk("mr_en", 32'(en), 32'd0);
    chk("mr_rv", 32'(result_valid), 32'd0);
    chk("mr_count", 32'(fifo_count), 32'd0);
    chk("mr_issued", 32'(issued_cnt), 32'd0);
    chk("mr_ready", 32'(cmd_bus.cmd_ready), 32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    tick();
    rst_issue = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_post_en", 32'(en), 32'd0);
      chk("mr_post_count", 32'(fifo_count), 32'd0);
      chk("mr_post_issued", 32'(issued_cnt), 32'd0);
    end
    $display("mid-burst reset sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
